// File: rtl/clock_ctrl.sv
// Mode/advance controller for the digital clock: 1 Hz time base, RUN/SET_HOUR/SET_MIN
// mode machine with auto-repeat increment, and blink blanking of the field being set.
module clock_ctrl #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int HOLD_CYC      = 500,
    parameter int REPEAT_CYC    = 100
) (
    input  logic       in_clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       sec_max,
    input  logic       min_max,
    output logic       sec_adv,
    output logic       min_adv,
    output logic       hour_adv,
    output logic       sec_clr,
    output logic [1:0] mode,
    output logic       blank_hour,
    output logic       blank_min
);
    localparam int PW   = $clog2(TICKS_PER_SEC);
    localparam int HMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int HW   = $clog2(HMAX + 1);
    localparam logic [PW-1:0] PCNT_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0] PCNT_HALF = PW'(TICKS_PER_SEC / 2);
    localparam logic [HW-1:0] HOLD_V    = HW'(HOLD_CYC);
    localparam logic [HW-1:0] REPEAT_V  = HW'(REPEAT_CYC);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    mode_sync_q, mode_sync_d, inc_sync_q, inc_sync_d;
    logic          mode_edge_q, mode_edge_d, inc_edge_q, inc_edge_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          rep_q, rep_d;
    logic          sec_adv_q, sec_adv_d, min_adv_q, min_adv_d;
    logic          hour_adv_q, hour_adv_d, sec_clr_q, sec_clr_d;
    logic [1:0]    mode_q, mode_d;
    logic          blank_hour_q, blank_hour_d, blank_min_q, blank_min_d;
    logic          tick_s, rep_fire_s, inc_ev_s;

    // Synchroniser chain [0]=stage1 [1]=stage2 [2]=history; registered edge decode.
    always_comb begin
        mode_sync_d = {mode_sync_q[1:0], btn_mode};
        inc_sync_d  = {inc_sync_q[1:0], btn_inc};
        mode_edge_d = mode_sync_q[1] & ~mode_sync_q[2];
        inc_edge_d  = inc_sync_q[1] & ~inc_sync_q[2];
    end

    // Next-state logic of the mode machine.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:      if (mode_edge_q) state_d = ST_SET_HOUR; else state_d = ST_RUN;
            ST_SET_HOUR: if (mode_edge_q) state_d = ST_SET_MIN;  else state_d = ST_SET_HOUR;
            ST_SET_MIN:  if (mode_edge_q) state_d = ST_RUN;      else state_d = ST_SET_MIN;
            default:     state_d = ST_RUN;
        endcase
    end

    // Prescaler, hold/repeat counter and increment-event qualification.
    always_comb begin
        tick_s     = (pcnt_q == PCNT_LAST);
        rep_fire_s = inc_sync_q[1] && (hold_cnt_q != '0) &&
                     (rep_q ? (hold_cnt_q == REPEAT_V) : (hold_cnt_q == HOLD_V));
        // A mode edge in the same cycle swallows the increment.
        inc_ev_s   = (state_q != ST_RUN) && !mode_edge_q && (inc_edge_q || rep_fire_s);

        if (mode_edge_q || inc_ev_s || tick_s) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PW'(1);
        end

        if ((state_q == ST_RUN) || mode_edge_q || !inc_sync_q[1]) begin
            hold_cnt_d = '0;
            rep_d      = 1'b0;
        end else if (inc_edge_q) begin
            hold_cnt_d = HW'(1);
            rep_d      = 1'b0;
        end else if (rep_fire_s) begin
            hold_cnt_d = HW'(1);
            rep_d      = 1'b1;
        end else if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
            rep_d      = rep_q;
        end else begin
            hold_cnt_d = hold_cnt_q;
            rep_d      = rep_q;
        end
    end

    // Output decode; everything lands in flops so the strobes are glitch-free.
    always_comb begin
        sec_adv_d    = (state_q == ST_RUN) && tick_s;
        min_adv_d    = ((state_q == ST_RUN) && tick_s && sec_max) ||
                       ((state_q == ST_SET_MIN) && inc_ev_s);
        hour_adv_d   = ((state_q == ST_RUN) && tick_s && sec_max && min_max) ||
                       ((state_q == ST_SET_HOUR) && inc_ev_s);
        sec_clr_d    = (state_q == ST_RUN) && mode_edge_q;
        mode_d       = state_d;
        blank_hour_d = (state_d == ST_SET_HOUR) && (pcnt_d >= PCNT_HALF);
        blank_min_d  = (state_d == ST_SET_MIN) && (pcnt_d >= PCNT_HALF);
    end

    // State registers; sync chains reset high so a button held through reset gives no edge.
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            mode_sync_q  <= 3'b111;
            inc_sync_q   <= 3'b111;
            mode_edge_q  <= 1'b0;
            inc_edge_q   <= 1'b0;
            pcnt_q       <= '0;
            hold_cnt_q   <= '0;
            rep_q        <= 1'b0;
            sec_adv_q    <= 1'b0;
            min_adv_q    <= 1'b0;
            hour_adv_q   <= 1'b0;
            sec_clr_q    <= 1'b0;
            mode_q       <= 2'b00;
            blank_hour_q <= 1'b0;
            blank_min_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_sync_q  <= mode_sync_d;
            inc_sync_q   <= inc_sync_d;
            mode_edge_q  <= mode_edge_d;
            inc_edge_q   <= inc_edge_d;
            pcnt_q       <= pcnt_d;
            hold_cnt_q   <= hold_cnt_d;
            rep_q        <= rep_d;
            sec_adv_q    <= sec_adv_d;
            min_adv_q    <= min_adv_d;
            hour_adv_q   <= hour_adv_d;
            sec_clr_q    <= sec_clr_d;
            mode_q       <= mode_d;
            blank_hour_q <= blank_hour_d;
            blank_min_q  <= blank_min_d;
        end
    end

    assign sec_adv    = sec_adv_q;
    assign min_adv    = min_adv_q;
    assign hour_adv   = hour_adv_q;
    assign sec_clr    = sec_clr_q;
    assign mode       = mode_q;
    assign blank_hour = blank_hour_q;
    assign blank_min  = blank_min_q;
endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl: strobe expectations go through a cycle-stamped scoreboard.
module tb_clock_ctrl;
    logic       in_clk = 1'b0;
    logic       rst, btn_mode, btn_inc, sec_max, min_max;
    logic       sec_adv, min_adv, hour_adv, sec_clr, blank_hour, blank_min;
    logic [1:0] mode;

    typedef struct {
        int         cyc;
        logic [3:0] stb;   // {sec_adv, min_adv, hour_adv, sec_clr}
    } exp_t;

    exp_t       sb_q[$];
    exp_t       ent;
    logic [3:0] stb_s;
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;

    clock_ctrl #(.TICKS_PER_SEC(10), .HOLD_CYC(8), .REPEAT_CYC(4)) dut (
        .in_clk(in_clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .sec_max(sec_max), .min_max(min_max), .sec_adv(sec_adv), .min_adv(min_adv),
        .hour_adv(hour_adv), .sec_clr(sec_clr), .mode(mode),
        .blank_hour(blank_hour), .blank_min(blank_min)
    );

    always #5 in_clk = ~in_clk;

    // Edge counter: edge k is the k-th rising edge after reset release.
    always @(posedge in_clk) begin
        if (!rst) cyc = 0;
        else      cyc = cyc + 1;
    end

    // Monitor: any strobe (or a due expectation) is compared against the scoreboard head.
    always @(negedge in_clk) begin
        if (rst === 1'b1) begin
            stb_s = {sec_adv, min_adv, hour_adv, sec_clr};
            if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                ent = sb_q.pop_front();
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL strobe_missed: expected %b at cycle %0d, not observed", ent.stb, ent.cyc);
            end
            if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                ent = sb_q.pop_front();
                checks = checks + 1;
                if (stb_s !== ent.stb) begin
                    errors = errors + 1;
                    $display("FAIL strobe_cycle_%0d: got %b expected %b", cyc, stb_s, ent.stb);
                end
            end else if (stb_s !== 4'b0000) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL strobe_unexpected: got %b expected 0000 at cycle %0d", stb_s, cyc);
            end
        end
    end

    task automatic push(input int c, input logic [3:0] s);
        exp_t e;
        e.cyc = c;
        e.stb = s;
        sb_q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge in_clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; sec_max = 1'b0; min_max = 1'b0;
        repeat (3) @(negedge in_clk);
        push(10, 4'b1000); push(20, 4'b1000); push(30, 4'b1000);
        rst = 1'b1;

        // RUN idle, then carry into minutes and hours.
        wait_until(35);
        check("mode_run_idle", 32'(mode), 0);
        check("blanks_run_idle", 32'({blank_hour, blank_min}), 0);
        sec_max = 1'b1; min_max = 1'b1;
        push(40, 4'b1110); push(50, 4'b1110); push(60, 4'b1000);
        wait_until(52);
        sec_max = 1'b0; min_max = 1'b0;

        // RUN -> SET_HOUR with one sec_clr.
        wait_until(61);
        btn_mode = 1'b1;
        push(65, 4'b0001);
        wait_until(63);
        btn_mode = 1'b0;
        wait_until(65);
        check("mode_set_hour", 32'(mode), 1);
        wait_until(69);
        check("blank_hour_pcnt4", 32'(blank_hour), 0);
        wait_until(70);
        check("blank_hour_pcnt5", 32'(blank_hour), 1);

        // Hold increment 20 cycles: first event, then +8, then every 4.
        wait_until(71);
        btn_inc = 1'b1;
        push(75, 4'b0010); push(83, 4'b0010); push(87, 4'b0010); push(91, 4'b0010);
        wait_until(91);
        btn_inc = 1'b0;

        // SET_HOUR -> SET_MIN, blink phase, increment re-clears phase.
        wait_until(96);
        btn_mode = 1'b1;
        wait_until(98);
        btn_mode = 1'b0;
        wait_until(100);
        check("mode_set_min", 32'(mode), 2);
        wait_until(104);
        check("blank_min_pcnt4", 32'(blank_min), 0);
        wait_until(105);
        check("blank_min_pcnt5", 32'(blank_min), 1);
        check("blank_hour_in_set_min", 32'(blank_hour), 0);
        wait_until(109);
        check("blank_min_pcnt9", 32'(blank_min), 1);
        wait_until(110);
        check("blank_min_wrap", 32'(blank_min), 0);
        wait_until(111);
        btn_inc = 1'b1;
        push(115, 4'b0100);
        wait_until(113);
        btn_inc = 1'b0;
        wait_until(115);
        check("blank_min_after_inc", 32'(blank_min), 0);
        wait_until(119);
        check("blank_min_inc_pcnt4", 32'(blank_min), 0);
        wait_until(120);
        check("blank_min_inc_pcnt5", 32'(blank_min), 1);

        // SET_MIN -> RUN; prescaler restarts from the transition.
        wait_until(121);
        btn_mode = 1'b1;
        wait_until(123);
        btn_mode = 1'b0;
        wait_until(125);
        check("mode_back_to_run", 32'(mode), 0);
        check("blank_min_in_run", 32'(blank_min), 0);
        push(135, 4'b1000);

        // Into SET_HOUR again, then mode and increment together: mode wins.
        wait_until(136);
        btn_mode = 1'b1;
        push(140, 4'b0001);
        wait_until(138);
        btn_mode = 1'b0;
        wait_until(144);
        btn_mode = 1'b1; btn_inc = 1'b1;
        wait_until(146);
        btn_mode = 1'b0; btn_inc = 1'b0;
        wait_until(148);
        check("mode_simultaneous", 32'(mode), 2);

        // Async reset with a min_adv strobe in flight; buttons held through release.
        wait_until(150);
        btn_inc = 1'b1;
        wait_until(153);
        check("mode_before_reset", 32'(mode), 2);
        @(posedge in_clk);
        #1;
        check("min_adv_in_flight", 32'(min_adv), 1);
        btn_mode = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("outputs_async_reset",
              32'({sec_adv, min_adv, hour_adv, sec_clr, mode, blank_hour, blank_min}), 0);
        @(negedge in_clk);
        @(negedge in_clk);
        push(10, 4'b1000);
        rst = 1'b1;
        wait_until(5);
        btn_mode = 1'b0; btn_inc = 1'b0;
        wait_until(8);
        check("mode_held_across_reset", 32'(mode), 0);
        wait_until(12);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
